// File: rtl/bcd_down_counter.sv
// Multi-digit packed-BCD down-counter with zero detect, terminal-count pulse and load validation.
// Define BCD_DOWN_COUNTER_RELOAD_EN for auto-reload mode; one-shot otherwise.
module bcd_down_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   LoadValue,
  input  logic                  Enable,
  output logic [4*DIGITS-1:0]   Count,
  output logic                  Zero,
  output logic                  Done,
  output logic                  LoadError
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ZERO_VAL = {W{1'b0}};
  localparam logic [W-1:0] ONE_VAL  = {{(W-1){1'b0}}, 1'b1};

  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // Digit-wise decrement: a 0 digit becomes 9 and passes the borrow upward.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          r[4*i +: 4] = 4'd9;
          borrow      = 1'b1;
        end else begin
          r[4*i +: 4] = d - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

  logic [W-1:0] count_r;
  logic [W-1:0] count_nxt_s;
  logic         done_r;
  logic         done_nxt_s;
  logic         lderr_r;
  logic         lderr_nxt_s;
`ifdef BCD_DOWN_COUNTER_RELOAD_EN
  logic [W-1:0] reload_r;
  logic [W-1:0] reload_nxt_s;
`endif

  // Next-state selection: Load beats Enable, Enable beats hold.
  always_comb begin
    count_nxt_s = count_r;
    done_nxt_s  = 1'b0;
    lderr_nxt_s = 1'b0;
`ifdef BCD_DOWN_COUNTER_RELOAD_EN
    reload_nxt_s = reload_r;
`endif
    if (Load) begin
      if (bcd_valid(LoadValue)) begin
        count_nxt_s = LoadValue;
`ifdef BCD_DOWN_COUNTER_RELOAD_EN
        reload_nxt_s = LoadValue;
`endif
      end else begin
        lderr_nxt_s = 1'b1;
      end
    end else if (Enable) begin
      if (count_r != ZERO_VAL) begin
        count_nxt_s = bcd_dec(count_r);
        done_nxt_s  = (count_r == ONE_VAL);
      end else begin
`ifdef BCD_DOWN_COUNTER_RELOAD_EN
        if (reload_r != ZERO_VAL) begin
          count_nxt_s = reload_r;
        end else begin
          count_nxt_s = count_r;
        end
`else
        count_nxt_s = count_r;
`endif
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      count_r <= ZERO_VAL;
      done_r  <= 1'b0;
      lderr_r <= 1'b0;
`ifdef BCD_DOWN_COUNTER_RELOAD_EN
      reload_r <= ZERO_VAL;
`endif
    end else begin
      count_r <= count_nxt_s;
      done_r  <= done_nxt_s;
      lderr_r <= lderr_nxt_s;
`ifdef BCD_DOWN_COUNTER_RELOAD_EN
      reload_r <= reload_nxt_s;
`endif
    end
  end

  assign Count     = count_r;
  assign Zero      = (count_r == ZERO_VAL);
  assign Done      = done_r;
  assign LoadError = lderr_r;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter with a decimal-integer reference model checked every cycle.
module tb_bcd_down_counter;

  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;

  logic         Clock = 1'b0;
  logic         ResetN;
  logic         Load;
  logic [W-1:0] LoadValue;
  logic         Enable;
  logic [W-1:0] Count;
  logic         Zero;
  logic         Done;
  logic         LoadError;

  int passed = 0;
  int total  = 0;

  int m_count  = 0;
  int m_reload = 0;
  bit m_done   = 1'b0;
  bit m_lderr  = 1'b0;

  bcd_down_counter #(.DIGITS(DIGITS)) dut (
    .Clock(Clock), .ResetN(ResetN), .Load(Load), .LoadValue(LoadValue),
    .Enable(Enable), .Count(Count), .Zero(Zero), .Done(Done), .LoadError(LoadError)
  );

  always #5 Clock = ~Clock;

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r;
    int v;
    v = n;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic bit is_valid(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] v);
    int s, p;
    s = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      s = s + int'(v[4*i +: 4]) * p;
      p = p * 10;
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Apply one cycle of inputs, advance the decimal model, then compare after the edge.
  task automatic tick(input bit rn, input bit ld, input logic [W-1:0] lv, input bit en);
    ResetN = rn; Load = ld; LoadValue = lv; Enable = en;
    m_done  = 1'b0;
    m_lderr = 1'b0;
    if (!rn) begin
      m_count  = 0;
      m_reload = 0;
    end else if (ld) begin
      if (is_valid(lv)) begin
        m_count  = from_bcd(lv);
        m_reload = m_count;
      end else begin
        m_lderr = 1'b1;
      end
    end else if (en) begin
      if (m_count > 0) begin
        m_count = m_count - 1;
        m_done  = (m_count == 0);
      end
`ifdef BCD_DOWN_COUNTER_RELOAD_EN
      else if (m_reload != 0) begin
        m_count = m_reload;
      end
`endif
    end
    @(posedge Clock);
    #1;
    chk("count", Count, to_bcd(m_count));
    chk1("zero", Zero, m_count == 0);
    chk1("done", Done, m_done);
    chk1("loaderror", LoadError, m_lderr);
  endtask

  initial begin
    ResetN = 1'b0; Load = 1'b0; LoadValue = '0; Enable = 1'b0;
    @(negedge Clock);
    tick(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("lit_reset_count", Count, 16'h0000);
    chk1("lit_reset_zero", Zero, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 16'h0000, 1'b1);
    chk("lit_idle_count", Count, 16'h0000);
    chk1("lit_idle_done", Done, 1'b0);

    // Count down from 3
    tick(1'b1, 1'b1, 16'h0003, 1'b0);
    chk("lit_load3", Count, 16'h0003);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    chk("lit_cnt1", Count, 16'h0001);
    chk1("lit_cnt1_done", Done, 1'b0);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    chk1("lit_first0_done", Done, 1'b1);
    chk1("lit_first0_zero", Zero, 1'b1);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    chk1("lit_second0_done", Done, 1'b0);

    // Borrow ripple
    tick(1'b1, 1'b1, 16'h1000, 1'b0);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    chk("lit_1000_dec", Count, 16'h0999);
    tick(1'b1, 1'b1, 16'h0100, 1'b0);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    chk("lit_0100_dec", Count, 16'h0099);
    tick(1'b1, 1'b1, 16'h9999, 1'b0);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    chk("lit_9999_dec", Count, 16'h9998);
    tick(1'b1, 1'b1, 16'h0010, 1'b1);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    chk("lit_0010_dec", Count, 16'h0009);

    // Rejected loads, then load-with-enable
    tick(1'b1, 1'b1, 16'h0042, 1'b0);
    tick(1'b1, 1'b1, 16'h00A5, 1'b1);
    chk1("lit_bad_lderr", LoadError, 1'b1);
    chk("lit_bad_hold", Count, 16'h0042);
    tick(1'b1, 1'b1, 16'h0007, 1'b1);
    chk("lit_ld_en", Count, 16'h0007);
    chk1("lit_ld_en_lderr", LoadError, 1'b0);
    tick(1'b1, 1'b1, 16'hF000, 1'b0);
    tick(1'b1, 1'b0, 16'h0000, 1'b0);
    tick(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("lit_hold", Count, 16'h0007);

    // Count==1 with Load gives no Done; loading 0 gives no Done
    tick(1'b1, 1'b1, 16'h0001, 1'b0);
    tick(1'b1, 1'b1, 16'h0000, 1'b1);
    chk1("lit_load0_done", Done, 1'b0);
    chk1("lit_load0_zero", Zero, 1'b1);

    // Reset mid-count
    tick(1'b1, 1'b1, 16'h0005, 1'b0);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    tick(1'b0, 1'b1, 16'h0004, 1'b1);
    chk("lit_midreset", Count, 16'h0000);
    chk1("lit_midreset_done", Done, 1'b0);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    chk("lit_after_reset", Count, 16'h0000);

    // Enable through zero: reload or hold depending on build
    tick(1'b1, 1'b1, 16'h0002, 1'b0);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    chk1("lit_wrap_done1", Done, 1'b1);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
`ifdef BCD_DOWN_COUNTER_RELOAD_EN
    chk("lit_reload", Count, 16'h0002);
`else
    chk("lit_oneshot", Count, 16'h0000);
`endif
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
`ifdef BCD_DOWN_COUNTER_RELOAD_EN
    chk1("lit_wrap_done2", Done, 1'b1);
`else
    chk1("lit_wrap_done2", Done, 1'b0);
`endif
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 16'h0000, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter.md
# bcd_down_counter

Parametrised multi-digit BCD down-counter with registered zero detection, terminal-count pulse and load validation. Generalises single-digit BCD zero detection to DIGITS packed digits and adds the counting state around it. Serves as the countdown/timer core feeding the BCD display path; Count drives the digit decoders directly.

## Interface
- DIGITS, default 4: number of BCD digits; legal range 1..8.
- Clock  input  1  rising-edge clock.
- ResetN  input  1  reset; reset is synchronous and active-low.
- Load  input  1  load LoadValue this cycle.
- LoadValue  input  4*DIGITS  packed BCD; digit 0 in [3:0].
- Enable  input  1  decrement by one this cycle.
- Count  output  4*DIGITS  registered current value, packed BCD.
- Zero  output  1  high when every digit of Count is 0; decoded from the Count register, so it changes in the same cycle as Count.
- Done  output  1  one-cycle registered pulse on a decrement from 1 to 0.
- LoadError  output  1  one-cycle registered pulse on a rejected load.

## Operation
- Reset (ResetN low at a rising edge): Count=0, internal ReloadReg=0, Done=0, LoadError=0. Zero therefore reads 1. Reset overrides Load and Enable.
- Priority each cycle: reset > Load > Enable > hold.
- Load with every digit in 0..9:
  - Count <= LoadValue and ReloadReg <= LoadValue.
  - LoadError <= 0. Done <= 0.
- Load with any digit in 10..15:
  - Load is rejected: Count and ReloadReg are unchanged.
  - LoadError <= 1 for exactly one cycle.
  - Enable is ignored in that cycle, because Load consumed the cycle.
- Enable with Count != 0 decrements in BCD:
  - Digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit up; higher digits are unaffected until a borrow reaches them.
  - Binary arithmetic is never used on the packed vector.
- Enable with Count == 1: Count <= 0 and Done <= 1 for that one cycle.
- Enable with Count == 0: behaviour depends on configuration (see Configuration).
- Done and LoadError are 0 in every cycle not described above.
- States, derived from the Count register:
  - ZERO (Count==0) goes to COUNTING on a valid nonzero Load.
  - COUNTING goes to ZERO on a decrement from 1, or on a valid Load of 0.
  - Loading 0 does not assert Done.

## Timing
- Load and Enable are sampled at the rising edge. Count, Done and LoadError update at that same edge, giving one-cycle latency. Zero follows Count combinationally.
- Enable held high continuously decrements once per cycle. N loaded reaches 0 after exactly N enabled cycles, and Done is high during the cycle in which Count first reads 0.
- Enable low holds Count indefinitely; Done stays low.
- Reset asserted mid-count: the next edge gives Count=0 and Done=0. No Done pulse is produced by reset.
- Load and Enable in the same cycle: the Load value is taken undecremented. Count == 1 with Load asserted produces no Done.
- Full-scale wrap within digits: e.g. 1000 -> 0999 in one cycle for DIGITS=4.

## Configuration
- BCD_DOWN_COUNTER_RELOAD_EN defined (auto-reload mode):
  - Enable with Count==0 and ReloadReg!=0 sets Count <= ReloadReg. The period is therefore ReloadReg+1 enabled cycles.
  - Done still pulses only on the 1 -> 0 decrement.
  - With ReloadReg==0, Count holds at 0.
- Macro not defined (one-shot mode):
  - Enable with Count==0 holds Count at 0. No wrap to all-9s and no Done.
  - ReloadReg may be optimised away.

## Test plan
- Reset then idle, DIGITS=4: Count=0000, Zero=1, Done=0, LoadError=0 for 5 cycles with Enable=1 (one-shot build).
- Load 0003, then Enable for 4 cycles -> Count 0003, 0002, 0001, 0000, 0000. Done is high only in the cycle Count first reads 0000. Zero rises in the same cycle.
- Load 1000, Enable 1 cycle -> 0999. Load 0100, Enable 1 cycle -> 0099 (borrow ripple).
- With Count=0042, Load 00A5 -> LoadError pulses 1 cycle and Count stays 0042. Then Load and Enable together with 0007 -> Count=0007, no decrement.
- Load 0005, Enable for 2 cycles, reset for 1 cycle -> Count=0000, Done never asserted. After release, Enable -> Count stays 0000 (one-shot).
- RELOAD_EN build: Load 0002, Enable continuous -> 0001, 0000 (Done), 0002, 0001, 0000 (Done); Done period is 3 cycles.
